// File: rtl/morse_symbol_reg_pkg.sv
// Shared symbol encodings and default character size for the Morse symbol register.
package morse_symbol_reg_pkg;
    localparam logic SYM_DOT        = 1'b0;
    localparam logic SYM_DASH       = 1'b1;
    localparam int   MORSE_MAX_SYMS = 5;
endpackage

// File: rtl/morse_symbol_reg_if.sv
// Symbol input, commit strobe and output slot handshake of the Morse symbol register.
interface morse_symbol_reg_if
    import morse_symbol_reg_pkg::*;
#(
    parameter int WIDTH = MORSE_MAX_SYMS,
    parameter int LEN_W = $clog2(WIDTH + 1)
);
    logic             sym_valid;
    logic             sym_bit;
    logic             commit;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_code;
    logic [LEN_W-1:0] out_len;
    logic             out_err;
    logic             full;
    logic             busy;

    modport master (
        output sym_valid, sym_bit, commit, out_ready,
        input  out_valid, out_code, out_len, out_err, full, busy
    );

    modport slave (
        input  sym_valid, sym_bit, commit, out_ready,
        output out_valid, out_code, out_len, out_err, full, busy
    );
endinterface

// File: rtl/morse_symbol_reg_shreg.sv
// Symbol accumulator: shifts symbols in MSB-first, counts them, flags overflow.
// A flush empties it, but a symbol arriving in the same cycle becomes the first symbol of the next character.
module morse_shreg
    import morse_symbol_reg_pkg::*;
#(
    parameter int WIDTH = MORSE_MAX_SYMS,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clear_n,
    input  logic             i_sym_vld,
    input  logic             i_sym_bit,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_code,
    output logic [LEN_W-1:0] o_len,
    output logic             o_ovf
);
    logic [WIDTH-1:0] r_code;
    logic [LEN_W-1:0] r_len;
    logic             r_ovf;
    logic             w_room;

    assign w_room = (r_len < LEN_W'(WIDTH));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_code <= '0;
            r_len  <= '0;
            r_ovf  <= 1'b0;
        end else if (!i_clear_n) begin
            r_code <= '0;
            r_len  <= '0;
            r_ovf  <= 1'b0;
        end else if (i_flush) begin
            r_ovf <= 1'b0;
            if (i_sym_vld) begin
                r_code <= {{(WIDTH-1){1'b0}}, i_sym_bit};
                r_len  <= LEN_W'(1);
            end else begin
                r_code <= '0;
                r_len  <= '0;
            end
        end else if (i_sym_vld) begin
            // Once full, extra symbols are dropped but remembered as an overflow.
            if (w_room) begin
                r_code <= {r_code[WIDTH-2:0], i_sym_bit};
                r_len  <= r_len + LEN_W'(1);
            end else begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign o_code = r_code;
    assign o_len  = r_len;
    assign o_ovf  = r_ovf;
endmodule

// File: rtl/morse_symbol_reg.sv
// Collects Morse symbols into characters and presents each committed character in a one-deep output slot.
// Commit-to-out_valid latency is 1 cycle; a commit is refused while the slot is full and not being drained.
module morse_symbol_reg
    import morse_symbol_reg_pkg::*;
#(
    parameter int WIDTH = MORSE_MAX_SYMS,
    parameter int LEN_W = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear_n,
    morse_symbol_reg_if.slave  bus
);
    logic [WIDTH-1:0] w_acc_code;
    logic [LEN_W-1:0] w_acc_len;
    logic             w_acc_ovf;
    logic             w_busy;
    logic             w_accept;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_code;
    logic [LEN_W-1:0] r_out_len;
    logic             r_out_err;

    assign w_busy   = r_out_valid && !bus.out_ready;
    assign w_accept = bus.commit && (w_acc_len != '0) && !w_busy;

    morse_shreg #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W)
    ) u_shreg (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear_n (clear_n),
        .i_sym_vld (bus.sym_valid),
        .i_sym_bit (bus.sym_bit),
        .i_flush   (w_accept),
        .o_code    (w_acc_code),
        .o_len     (w_acc_len),
        .o_ovf     (w_acc_ovf)
    );

    // A commit accepted while the consumer drains keeps the slot valid with the new character.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_code  <= '0;
            r_out_len   <= '0;
            r_out_err   <= 1'b0;
        end else if (!clear_n) begin
            r_out_valid <= 1'b0;
            r_out_code  <= '0;
            r_out_len   <= '0;
            r_out_err   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_code  <= w_acc_code;
            r_out_len   <= w_acc_len;
            r_out_err   <= w_acc_ovf;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_code  = r_out_code;
    assign bus.out_len   = r_out_len;
    assign bus.out_err   = r_out_err;
    assign bus.full      = (w_acc_len == LEN_W'(WIDTH));
    assign bus.busy      = w_busy;
endmodule

// File: tb/tb_morse_symbol_reg.sv
// Directed bench for morse_symbol_reg: a queue-based character model checked every cycle plus literal spot checks.
module tb_morse_symbol_reg;
    localparam int W  = 5;
    localparam int LW = $clog2(W + 1);

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic clear_n = 1'b1;

    morse_symbol_reg_if #(.WIDTH(W), .LEN_W(LW)) bus ();

    morse_symbol_reg #(.WIDTH(W), .LEN_W(LW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_n (clear_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: the pending character is a list of symbols; the slot is a plain record.
    bit acc_q[$];
    bit m_ovf   = 1'b0;
    bit m_valid = 1'b0;
    int m_code  = 0;
    int m_len   = 0;
    bit m_err   = 1'b0;

    function automatic int pack_symbols();
        int code = 0;
        foreach (acc_q[i]) code = code * 2 + int'(acc_q[i]);
        return code;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n || !clear_n) begin
            acc_q.delete();
            m_ovf = 0; m_valid = 0; m_code = 0; m_len = 0; m_err = 0;
        end else begin
            bit accept;
            accept = bus.commit && acc_q.size() > 0 && !(m_valid && !bus.out_ready);
            if (accept) begin
                m_valid = 1; m_code = pack_symbols(); m_len = acc_q.size(); m_err = m_ovf;
                acc_q.delete();
                m_ovf = 0;
            end else if (m_valid && bus.out_ready) begin
                m_valid = 0;
            end
            if (bus.sym_valid) begin
                if (acc_q.size() < W) acc_q.push_back(bus.sym_bit);
                else m_ovf = 1;
            end
        end
    end

    always @(negedge clk) begin
        check("model_valid", int'(bus.out_valid), int'(m_valid));
        check("model_code",  int'(bus.out_code),  m_code);
        check("model_len",   int'(bus.out_len),   m_len);
        check("model_err",   int'(bus.out_err),   int'(m_err));
        check("model_full",  int'(bus.full),      int'(acc_q.size() == W));
        check("model_busy",  int'(bus.busy),      int'(m_valid && !bus.out_ready));
    end

    task automatic cyc(input bit sv, input bit sb, input bit cm);
        bus.sym_valid = sv;
        bus.sym_bit   = sb;
        bus.commit    = cm;
        @(posedge clk);
        #1;
        bus.sym_valid = 1'b0;
        bus.commit    = 1'b0;
    endtask

    task automatic check_slot(input string tag, input int v, input int code, input int len, input int err);
        check({tag, "_valid"}, int'(bus.out_valid), v);
        check({tag, "_code"},  int'(bus.out_code),  code);
        check({tag, "_len"},   int'(bus.out_len),   len);
        check({tag, "_err"},   int'(bus.out_err),   err);
    endtask

    initial begin
        bus.sym_valid = 1'b0;
        bus.sym_bit   = 1'b0;
        bus.commit    = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_slot("reset", 0, 0, 0, 0);
        check("reset_full", int'(bus.full), 0);
        reset_n = 1'b1;

        // dash, dot, dash then commit with the consumer stalled
        cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 1, 0); cyc(0, 0, 1);
        check_slot("basic", 1, 5, 3, 0);
        check("basic_busy", int'(bus.busy), 1);
        bus.out_ready = 1'b1; cyc(0, 0, 0);
        check("drain_valid", int'(bus.out_valid), 0);
        bus.out_ready = 1'b0;

        // six dots into a five-symbol character
        repeat (6) cyc(1, 0, 0);
        check("ovf_full", int'(bus.full), 1);
        cyc(0, 0, 1);
        check_slot("ovf", 1, 0, 5, 1);
        check("ovf_full_after", int'(bus.full), 0);
        bus.out_ready = 1'b1; cyc(0, 0, 0); bus.out_ready = 1'b0;

        // commit coincident with a dash: dash,dot committed, dash starts the next character
        cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 1, 1);
        check_slot("simul", 1, 2, 2, 0);
        bus.out_ready = 1'b1; cyc(0, 0, 1);
        check_slot("simul_next", 1, 1, 1, 0);
        cyc(0, 0, 0);
        check("simul_drain", int'(bus.out_valid), 0);
        bus.out_ready = 1'b0;

        // backpressure: second commit refused, then accepted during the drain
        cyc(1, 1, 0); cyc(0, 0, 1);
        cyc(1, 0, 0); cyc(1, 0, 0); cyc(0, 0, 1);
        check_slot("refused", 1, 1, 1, 0);
        check("refused_busy", int'(bus.busy), 1);
        bus.out_ready = 1'b1; cyc(0, 0, 1);
        check_slot("drain_commit", 1, 0, 2, 0);
        check("drain_commit_busy", int'(bus.busy), 0);
        cyc(0, 0, 0); bus.out_ready = 1'b0;

        // empty commit, then clear mid-character with the slot occupied
        cyc(0, 0, 1);
        check("empty_valid", int'(bus.out_valid), 0);
        cyc(1, 1, 0); cyc(0, 0, 1); cyc(1, 0, 0);
        clear_n = 1'b0; cyc(1, 1, 1);
        check_slot("clear", 0, 0, 0, 0);
        check("clear_full", int'(bus.full), 0);
        clear_n = 1'b1; cyc(0, 0, 1);
        check("clear_empty", int'(bus.out_valid), 0);

        // async reset between edges, mid-character with the slot occupied
        cyc(1, 1, 0); cyc(1, 1, 0); cyc(0, 0, 1);
        check_slot("pre_rst", 1, 3, 2, 0);
        cyc(1, 0, 0);
        #2 reset_n = 1'b0;
        #1;
        check_slot("async_rst", 0, 0, 0, 0);
        check("async_rst_full", int'(bus.full), 0);
        @(posedge clk); #1 reset_n = 1'b1;
        cyc(1, 0, 0); cyc(0, 0, 1);
        check_slot("post_rst", 1, 0, 1, 0);

        repeat (2) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/morse_symbol_reg.md
MORSE_SYMBOL_REG -- requirements
Module: morse_symbol_reg

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; clk and reset_n are the first two ports.
REQ-002 Parameter: WIDTH, 5, maximum symbols per character (legal range 2..8).
REQ-003 Parameter: LEN_W, $clog2(WIDTH+1), width of the length fields.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 clear_n  input  1  synchronous active-low clear.
REQ-007 sym_valid  input  1  a symbol is present this cycle.
REQ-008 sym_bit  input  1  symbol value: 0 = dot, 1 = dash.
REQ-009 commit  input  1  end-of-character strobe.
REQ-010 out_ready  input  1  consumer accepts the output slot.
REQ-011 out_valid  output  1  output slot holds a committed character.
REQ-012 out_code  output  WIDTH  committed symbols, first symbol at bit len-1, last at bit 0, upper bits 0.
REQ-013 out_len  output  LEN_W  committed symbol count (1..WIDTH).
REQ-014 out_err  output  1  committed character overflowed.
REQ-015 full  output  1  accumulator length == WIDTH.
REQ-016 busy  output  1  out_valid && !out_ready (a commit this cycle would be refused).

Function
REQ-017 The accumulator SHALL hold acc_code, acc_len and a sticky acc_ovf flag.
REQ-018 When sym_valid=1 and acc_len<WIDTH, the block SHALL set acc_code to {acc_code[WIDTH-2:0], sym_bit} and increment acc_len on the next edge.
REQ-019 When sym_valid=1 and acc_len==WIDTH, the block SHALL leave acc_code and acc_len unchanged and set acc_ovf.
REQ-020 A commit SHALL be accepted when commit=1, acc_len>0 and (out_valid=0 or out_ready=1).
REQ-021 An accepted commit SHALL load out_code/out_len/out_err from acc_code/acc_len/acc_ovf and set out_valid=1 on the next edge; latency is 1 cycle.
REQ-022 An accepted commit SHALL also clear the accumulator on the next edge.
REQ-023 If sym_valid and an accepted commit occur together, the new symbol SHALL become the first symbol of the cleared accumulator (acc_len=1, acc_code=sym_bit).
REQ-024 A commit with acc_len==0 SHALL be ignored, with no output change.
REQ-025 A commit refused because busy=1 SHALL leave the accumulator intact; symbols continue to be accepted per REQ-018/019.
REQ-026 When out_valid=1 and out_ready=1 and no commit is accepted, out_valid SHALL go to 0 on the next edge.
REQ-027 out_code, out_len and out_err SHALL stay stable while out_valid=1 and out_ready=0.
REQ-028 clear_n=0 at a rising edge SHALL zero the accumulator, acc_ovf, out_valid, out_code, out_len and out_err, overriding sym_valid and commit.
REQ-029 full and busy SHALL be combinational from registered state and out_ready.

Reset
REQ-030 reset_n=0 SHALL immediately, without waiting for clk, force all registers to 0: out_valid=0, out_code=0, out_len=0, out_err=0, full=0, and acc_* = 0.
REQ-031 Reset asserted mid-character or with out_valid=1 SHALL discard all data; the first post-reset edge behaves as from idle.

Structure
REQ-032 A shared package SHALL hold SYM_DOT=1'b0, SYM_DASH=1'b1 and MORSE_MAX_SYMS=5.
REQ-033 The accumulator SHALL be one sub-module, morse_shreg, covering REQ-018/019/022/023 with its own clear input.
REQ-034 The output slot and handshake logic SHALL live in the top level.

Verification
REQ-035 Reset and idle: sym dash,dot,dash then commit with out_ready=0 -> out_valid=1, out_code=5'b00101, out_len=3, out_err=0; busy=1.
REQ-036 Overflow: 6 dots with WIDTH=5, then commit -> out_len=5, out_code=0, out_err=1, full=1 before the commit.
REQ-037 Simultaneous events: commit together with sym_valid=1 (dash) -> committed char correct; accumulator len=1, code=1.
REQ-038 Backpressure: second commit while busy=1 -> refused, first output unchanged; raise out_ready -> next commit accepted in the same cycle as the drain, out_valid stays 1 with new data.
REQ-039 Empty and clear: commit with acc_len=0 -> no out_valid; clear_n=0 mid-character with out_valid=1 -> all outputs 0 next edge.
REQ-040 Async reset: assert reset_n=0 between clock edges mid-character -> outputs 0 before the next edge.
